// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_wr_arbiter                                              |
// | Description : Round-robin arbiter sharing the single write port of the     |
// |               8-bit synchronous fifo among NUM_REQ producers. A winner     |
// |               keeps the port for a burst of up to BURST_LEN words; the     |
// |               fifo full flag stalls the burst without ending it.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk           in   1               system clock, rising edge             |
// |   rst           in   1               asynchronous reset, active-high       |
// |   req           in   NUM_REQ         requester i has a valid word          |
// |   req_data      in   NUM_REQ*DATA_W  lane i = req_data[i*DATA_W +: DATA_W] |
// |   gnt           out  NUM_REQ         one-hot, lane i word written now      |
// |   fifo_full     in   1               fifo full flag                        |
// |   fifo_we       out  1               fifo write enable                     |
// |   fifo_data_in  out  DATA_W          fifo write data                       |
// |   busy          out  1               high while a burst is open            |
// |   wr_count      out  16              (FIFO_ARB_STATS_EN) words written     |
// |   stall_count   out  16              (FIFO_ARB_STATS_EN) stalled cycles    |
// | Configuration                                                              |
// |   FIFO_ARB_STATS_EN  when defined, adds saturating write/stall counters.   |
// +----------------------------------------------------------------------------+

module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int BURST_LEN = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        gnt,
   input  logic                      fifo_full,
   output logic                      fifo_we,
   output logic [DATA_W-1:0]         fifo_data_in,
   output logic                      busy
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [15:0]               wr_count,
   output logic [15:0]               stall_count
`endif
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(BURST_LEN) + 1;

   localparam logic [PTR_W:0]   c_num_req_ext = (PTR_W+1)'(NUM_REQ);
   localparam logic [PTR_W-1:0] c_last_req    = PTR_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] c_last_beat   = CNT_W'(BURST_LEN - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]   owner_q, owner_d;
   logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

   logic [DATA_W-1:0]  w_lane [NUM_REQ];
   logic               w_found;
   logic [PTR_W-1:0]   w_pick;
   logic [PTR_W:0]     w_idx;
   logic [PTR_W-1:0]   w_next_ptr;
   logic               w_write;

   // Unpack the flat lane bus so the owner can index it directly.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
         assign w_lane[gi] = req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Round-robin search starting at rr_ptr. Offsets are scanned from the
   // farthest down to zero so the closest requester (lowest offset) is the
   // last assignment and therefore wins.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
         if (w_idx >= c_num_req_ext) begin
            w_idx = w_idx - c_num_req_ext;
         end
         if (req[w_idx[PTR_W-1:0]]) begin
            w_found = 1'b1;
            w_pick  = w_idx[PTR_W-1:0];
         end
      end
   end

   // Pointer handed on when the current owner gives up the port.
   assign w_next_ptr = (owner_q == c_last_req) ? '0 : owner_q + 1'b1;

   // Next-state logic. A write needs an open burst, a word from the owner
   // and room in the fifo; everything else is either a stall or a release.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      beat_cnt_d = beat_cnt_q;
      w_write    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            beat_cnt_d = '0;
            if (w_found) begin
               owner_d = w_pick;
               state_d = ST_BURST;
            end
         end
         ST_BURST: begin
            if (req[owner_q]) begin
               if (!fifo_full) begin
                  w_write    = 1'b1;
                  beat_cnt_d = beat_cnt_q + 1'b1;
                  if (beat_cnt_q == c_last_beat) begin
                     state_d  = ST_IDLE;
                     rr_ptr_d = w_next_ptr;
                  end
               end
               // full with req held: stall, nothing changes
            end else begin
               state_d  = ST_IDLE;
               rr_ptr_d = w_next_ptr;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   // Outputs decode from registered state plus the live owner request and
   // full flag, so an asynchronous reset drops them at once.
   assign fifo_we      = w_write;
   assign gnt          = w_write ? (NUM_REQ'(1) << owner_q) : '0;
   assign fifo_data_in = w_write ? w_lane[owner_q] : '0;
   assign busy         = (state_q == ST_BURST);

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] wr_count_q, wr_count_d;
   logic [15:0] stall_count_q, stall_count_d;
   logic        w_stall;

   assign w_stall = (state_q == ST_BURST) && req[owner_q] && fifo_full;

   // Both counters stick at all-ones rather than wrapping.
   always_comb begin
      wr_count_d    = wr_count_q;
      stall_count_d = stall_count_q;
      if (w_write && (wr_count_q != 16'hFFFF)) begin
         wr_count_d = wr_count_q + 16'd1;
      end
      if (w_stall && (stall_count_q != 16'hFFFF)) begin
         stall_count_d = stall_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_count_q    <= '0;
         stall_count_q <= '0;
      end else begin
         wr_count_q    <= wr_count_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign wr_count    = wr_count_q;
   assign stall_count = stall_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fifo_wr_arbiter                                           |
// | Description : Self-checking bench for fifo_wr_arbiter. Directed producer   |
// |               scenarios followed by randomized traffic, all compared       |
// |               against a cycle-level reference model of the arbiter rules.  |
// |               Honours FIFO_ARB_STATS_EN for the optional counters.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module tb_fifo_wr_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int BL = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   gnt;
   logic           fifo_full;
   logic           fifo_we;
   logic [W-1:0]   fifo_data_in;
   logic           busy;
`ifdef FIFO_ARB_STATS_EN
   logic [15:0]    wr_count;
   logic [15:0]    stall_count;
`endif

   fifo_wr_arbiter #(
      .NUM_REQ   (N),
      .DATA_W    (W),
      .BURST_LEN (BL)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .req_data     (req_data),
      .gnt          (gnt),
      .fifo_full    (fifo_full),
      .fifo_we      (fifo_we),
      .fifo_data_in (fifo_data_in),
      .busy         (busy)
`ifdef FIFO_ARB_STATS_EN
      ,
      .wr_count     (wr_count),
      .stall_count  (stall_count)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference model: burst open?, who owns it, words written, search start.
   bit m_busy;
   int m_owner, m_beats, m_ptr;
   int m_wr, m_stall;
   int cyc = 0;

   // Log of observed writes (data, lane, cycle) for scenario-level checks.
   logic [W-1:0] wlog[$];
   int           llog[$];
   int           clog[$];

   // Producer word stores for the directed scenarios.
   logic [W-1:0] pw [N][32];
   int           ph [N];
   int           pt [N];

   function automatic int pick(input int ptr, input logic [N-1:0] rq);
      for (int k = 0; k < N; k++) begin
         if (rq[(ptr + k) % N]) return (ptr + k) % N;
      end
      return 0;
   endfunction

   // One clock: drive at negedge, check 1ns later, advance the model.
   task automatic step(input bit r, input logic [N-1:0] rq, input logic [N*W-1:0] d,
                       input bit full, output logic [N-1:0] e_gnt);
      bit           e_we;
      logic [W-1:0] e_data;
      int           lane;
      @(negedge clk);
      rst = r; req = rq; req_data = d; fifo_full = full;
      #1;
      cyc++;
      if (r) begin
         m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0; m_wr = 0; m_stall = 0;
      end
      e_we   = m_busy && rq[m_owner] && !full;
      e_gnt  = e_we ? (N'(1) << m_owner) : '0;
      e_data = e_we ? d[m_owner*W +: W] : '0;
      check_eq("gnt", gnt, e_gnt);
      check_eq("fifo_we", fifo_we, e_we);
      check_eq("fifo_data_in", fifo_data_in, e_data);
      check_eq("busy", busy, m_busy);
      check_eq("we_while_full", fifo_we & fifo_full, 0);
`ifdef FIFO_ARB_STATS_EN
      check_eq("wr_count", wr_count, m_wr);
      check_eq("stall_count", stall_count, m_stall);
`endif
      if (fifo_we) begin
         lane = -1;
         for (int i = N - 1; i >= 0; i--) if (gnt[i]) lane = i;
         wlog.push_back(fifo_data_in);
         llog.push_back(lane);
         clog.push_back(cyc);
      end
      if (!r) begin
         if (e_we && m_wr < 65535) m_wr++;
         if (m_busy && rq[m_owner] && full && m_stall < 65535) m_stall++;
         if (!m_busy) begin
            if (rq != '0) begin
               m_owner = pick(m_ptr, rq);
               m_beats = 0;
               m_busy  = 1;
            end
         end else if (e_we) begin
            m_beats++;
            if (m_beats == BL) begin
               m_busy = 0;
               m_ptr  = (m_owner + 1) % N;
            end
         end else if (!rq[m_owner]) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % N;
         end
      end
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) begin ph[i] = 0; pt[i] = 0; end
      wlog.delete(); llog.delete(); clog.delete();
   endtask

   task automatic push_word(input int lane, input logic [W-1:0] v);
      pw[lane][pt[lane]] = v;
      pt[lane]++;
   endtask

   // Producers offer their head word and pop it when the model grants them.
   task automatic prod_step(input bit full);
      logic [N-1:0]   rq;
      logic [N*W-1:0] d;
      logic [N-1:0]   g;
      rq = '0; d = '0;
      for (int i = 0; i < N; i++) begin
         if (ph[i] != pt[i]) begin
            rq[i] = 1'b1;
            d[i*W +: W] = pw[i][ph[i]];
         end
      end
      step(1'b0, rq, d, full, g);
      for (int i = 0; i < N; i++) if (g[i]) ph[i]++;
   endtask

   task automatic do_reset();
      logic [N-1:0] g;
      step(1'b1, '0, '0, 1'b0, g);
      step(1'b1, '0, '0, 1'b0, g);
   endtask

   initial begin
      logic [N-1:0]   g;
      logic [N-1:0]   rq;
      logic [N*W-1:0] d;
      rst = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0;

      // Reset state
      do_reset();

      // Single lane: six words on lane 1, burst of four, gap, then two more
      clear_all();
      for (int k = 0; k < 6; k++) push_word(1, 8'h11 + 8'(k));
      for (int c = 0; c < 10; c++) prod_step(1'b0);
      check_eq("single_count", wlog.size(), 6);
      for (int k = 0; k < 6; k++) begin
         if (wlog.size() > k) begin
            check_eq("single_data", wlog[k], 8'h11 + 8'(k));
            check_eq("single_lane", llog[k], 1);
         end
      end
      if (clog.size() >= 5) check_eq("single_gap", clog[4] - clog[3], 2);

      // All lanes continuously: order 0,1,2,3,0 then reset mid-burst
      do_reset();
      clear_all();
      for (int c = 0; c < 23; c++) step(1'b0, 4'b1111, N*W'($urandom), 1'b0, g);
      check_eq("rr_count", wlog.size(), 18);
      for (int k = 0; k < 18; k++) begin
         if (llog.size() > k) check_eq("rr_lane", llog[k], (k / BL) % N);
      end
      check_eq("pre_reset_busy", busy, 1);
      step(1'b1, 4'b1111, '1, 1'b0, g);
      step(1'b1, 4'b1111, '1, 1'b0, g);
      clear_all();
      for (int c = 0; c < 3; c++) step(1'b0, 4'b1100, N*W'($urandom), 1'b0, g);
      if (llog.size() > 0) check_eq("post_reset_lane", llog[0], 2);
      else check_eq("post_reset_write", 0, 1);

      // Back-pressure: full for three cycles after the second lane-0 word
      do_reset();
      clear_all();
      for (int k = 0; k < 4; k++) push_word(0, 8'hA0 + 8'(k));
      for (int k = 0; k < 2; k++) push_word(1, 8'hB0 + 8'(k));
      for (int c = 0; c < 12; c++) prod_step(c >= 3 && c <= 5);
      check_eq("bp_count", wlog.size(), 6);
      for (int k = 0; k < 6; k++) begin
         if (llog.size() > k) check_eq("bp_lane", llog[k], (k < 4) ? 0 : 1);
      end
      if (clog.size() >= 3) check_eq("bp_stall_gap", clog[2] - clog[1], 4);
`ifdef FIFO_ARB_STATS_EN
      check_eq("bp_stalls", stall_count, 3);
`endif

      // Early release: lane 2 gives one word, pointer moves to 3 ahead of 0
      do_reset();
      clear_all();
      push_word(2, 8'hC0);
      push_word(3, 8'hD0);
      push_word(3, 8'hD1);
      prod_step(1'b0);
      prod_step(1'b0);
      push_word(0, 8'hE0);
      push_word(0, 8'hE1);
      for (int c = 0; c < 10; c++) prod_step(1'b0);
      check_eq("er_count", wlog.size(), 5);
      for (int k = 0; k < 5; k++) begin
         if (llog.size() > k) check_eq("er_lane", llog[k], (k == 0) ? 2 : (k < 3) ? 3 : 0);
      end

      // Randomized traffic with back-pressure and occasional reset
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         rq = '0;
         for (int i = 0; i < N; i++) rq[i] = ($urandom_range(0, 4) != 0);
         d = N*W'($urandom);
         step($urandom_range(0, 199) == 0, rq, d, $urandom_range(0, 3) == 0, g);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
